// File: rtl/tc_pkg.sv
// +--------------------------------------------------------------------+
// | tc_pkg : shared types and constants for the memory-mapped timer     |
// | Revision: 1.0                                                       |
// +--------------------------------------------------------------------+
`default_nettype none

package tc_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_LOAD = 2'd1,
      ST_CNT  = 2'd2,
      ST_INT  = 2'd3
   } tc_state_e;

   localparam logic [1:0] REG_CTRL   = 2'b00;
   localparam logic [1:0] REG_PRESET = 2'b01;
   localparam logic [1:0] REG_COUNT  = 2'b10;

   localparam int CTRL_EN      = 0;
   localparam int CTRL_MODE_LO = 1;
   localparam int CTRL_MODE_HI = 2;
   localparam int CTRL_IM      = 3;

   localparam logic [1:0] MODE_ONESHOT = 2'b00;
   localparam logic [1:0] MODE_AUTO    = 2'b01;

endpackage

`default_nettype wire

// File: rtl/timer_counter.sv
// +--------------------------------------------------------------------+
// | timer_counter : memory-mapped down-counting timer with IRQ          |
// | Revision: 1.0                                                       |
// +--------------------------------------------------------------------+
`default_nettype none

module timer_counter
   import tc_pkg::*;
#(
   parameter logic [31:0] BASE_ADDR = 32'h0000_7F00
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [31:0] Addr,
   input  logic        WE,
   input  logic [31:0] Din,
   output logic [31:0] Dout,
   output logic        IRQ
);

   tc_state_e   state_q, state_d;
   logic [3:0]  ctrl_q, ctrl_d;
   logic [31:0] preset_q, preset_d;
   logic [31:0] count_q, count_d;
   logic        irq_q, irq_d;

   logic        hit;
   logic        wr_en;
   logic [1:0]  mode;
   logic        unused_addr_bits;

   assign hit              = (Addr[31:4] == BASE_ADDR[31:4]);
   assign wr_en            = WE & hit;
   assign mode             = ctrl_q[CTRL_MODE_HI:CTRL_MODE_LO];
   assign unused_addr_bits = ^Addr[1:0];
   assign IRQ              = ctrl_q[CTRL_IM] & irq_q;

   always_comb begin
      Dout = '0;
      if (hit) begin
         case (Addr[3:2])
            REG_CTRL:   Dout = {28'd0, ctrl_q};
            REG_PRESET: Dout = preset_q;
            REG_COUNT:  Dout = count_q;
            default:    Dout = '0;
         endcase
      end
   end

   always_comb begin
      state_d  = state_q;
      ctrl_d   = ctrl_q;
      preset_d = preset_q;
      count_d  = count_q;
      irq_d    = irq_q;

      case (state_q)
         ST_IDLE: begin
            if (ctrl_q[CTRL_EN]) state_d = ST_LOAD;
         end
         ST_LOAD: begin
            count_d = preset_q;
            state_d = ST_CNT;
         end
         ST_CNT: begin
            if (!ctrl_q[CTRL_EN]) begin
               state_d = ST_IDLE;
            end else if (count_q > 32'd1) begin
               count_d = count_q - 32'd1;
            end else begin
               count_d = '0;
               irq_d   = 1'b1;
               state_d = ST_INT;
               // Every mode other than auto-reload is one-shot.
               if (mode != MODE_AUTO) ctrl_d[CTRL_EN] = 1'b0;
            end
         end
         ST_INT: begin
            state_d = ST_IDLE;
            if (mode == MODE_AUTO) irq_d = 1'b0;
         end
         default: state_d = ST_IDLE;
      endcase

      // Software writes are applied last so they override FSM updates.
      if (wr_en) begin
         case (Addr[3:2])
            REG_CTRL: begin
               ctrl_d = Din[3:0];
               irq_d  = 1'b0;
            end
            REG_PRESET: preset_d = Din;
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q  <= ST_IDLE;
         ctrl_q   <= '0;
         preset_q <= '0;
         count_q  <= '0;
         irq_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         ctrl_q   <= ctrl_d;
         preset_q <= preset_d;
         count_q  <= count_d;
         irq_q    <= irq_d;
      end
   end

endmodule

`default_nettype wire
